flash_tile_loader: RTL

//  Downstream stage of the background scroll controller. On each new tile-row or attribute-row request it

---
 rtl/ppu_flash_pkg.sv | 32 +++
 rtl/spi_byte_engine.sv | 82 ++++++++
 rtl/flash_tile_loader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_flash_pkg.sv
// ppu_flash_pkg: opcodes, loader state and row sizes shared by the flash loader and scroll controller.
// FLASH_FAST_READ_EN selects the FAST READ opcode as the loader command.
package ppu_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] LD_OPCODE = OP_FAST_READ;
`else
  localparam logic [7:0] LD_OPCODE = OP_READ;
`endif

  localparam int NAME_ROW_BYTES = 32;
  localparam int ATTR_ROW_BYTES = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DONE
  } ld_state_e;

  typedef struct packed {
    logic        attr;
    logic [23:0] faddr;
    logic [8:0]  ram;
  } ld_req_t;

endpackage

// File: rtl/spi_byte_engine.sv
// spi_byte_engine: mode-0 SPI byte shifter, CLK_DIV clocks per SCK half-period.
// done is a one-cycle strobe ahead of the last falling edge so a new byte can follow seamlessly.
module spi_byte_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       miso,
  output logic       busy,
  output logic       done,
  output logic [7:0] byte_out,
  output logic       sck,
  output logic       mosi
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          act_q, act_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic          sck_q, sck_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          tick;

  assign tick     = act_q && (div_q == DW'(CLK_DIV - 1));
  assign done     = tick && sck_q && (bit_q == 3'd7);
  assign busy     = act_q;
  assign byte_out = rx_q;
  assign sck      = sck_q;
  assign mosi     = tx_q[7];

  always_comb begin
    act_d = act_q;
    div_d = div_q;
    bit_d = bit_q;
    sck_d = sck_q;
    tx_d  = tx_q;
    rx_d  = rx_q;
    if (act_q) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        sck_d = ~sck_q;
        if (!sck_q) begin
          rx_d = {rx_q[6:0], miso};
        end else begin
          bit_d = bit_q + 3'd1;
          tx_d  = {tx_q[6:0], 1'b0};
          if (bit_q == 3'd7) act_d = 1'b0;
        end
      end
    end
    if (start && (!act_q || done)) begin
      act_d = 1'b1;
      div_d = '0;
      bit_d = '0;
      sck_d = 1'b0;
      tx_d  = byte_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_q <= 1'b0;
      div_q <= '0;
      bit_q <= '0;
      sck_q <= 1'b0;
      tx_q  <= '0;
      rx_q  <= '0;
    end else begin
      act_q <= act_d;
      div_q <= div_d;
      bit_q <= bit_d;
      sck_q <= sck_d;
      tx_q  <= tx_d;
      rx_q  <= rx_d;
    end
  end

endmodule

// File: rtl/flash_tile_loader.sv
// flash_tile_loader: reads nametable/attribute row bursts from SPI NOR and writes 32-bit RAM words.
// Define FLASH_FAST_READ_EN for FAST READ (0x0B) with one dummy byte before data.
module flash_tile_loader
  import ppu_flash_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int NAME_BYTES = NAME_ROW_BYTES,
  parameter int ATTR_BYTES = ATTR_ROW_BYTES
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [23:0] flashAddrNametable,
  input  logic [23:0] flashAddrAttribute,
  input  logic        flashReadNametableFlag,
  input  logic        flashReadAttributeFlag,
  input  logic [8:0]  nametableRamAddrStart,
  input  logic [8:0]  attributeRamAddrStart,
  output logic [3:0]  writeNameEn,
  output logic [8:0]  writeNameAddr,
  output logic [31:0] writeNameData,
  output logic [3:0]  writeAttrEn,
  output logic [8:0]  writeAttrAddr,
  output logic [31:0] writeAttrData,
  output logic        busy,
  output logic        SPI_CLK,
  output logic        SPI_CS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  localparam int IW = 16;

  ld_state_e   state_q, state_d;
  ld_req_t     shn_q, shn_d, sha_q, sha_d, cur_q, cur_d;
  logic        flagn_q, flaga_q;
  logic        pendn_q, pendn_d, penda_q, penda_d;
  logic [IW-1:0] idx_q, idx_d, hold_q, hold_d;
  logic [23:0] word_q, word_d;
  logic        cs_q, cs_d, busy_q, busy_d;
  logic [3:0]  nen_q, nen_d, aen_q, aen_d;
  logic [8:0]  naddr_q, naddr_d, aaddr_q, aaddr_d;
  logic [31:0] ndata_q, ndata_d, adata_q, adata_d;

  logic        rise_n, rise_a, take_n, take_a, last;
  logic        eng_start, eng_busy, eng_done;
  logic [7:0]  eng_tx, eng_rx;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;

  spi_byte_engine #(.CLK_DIV(CLK_DIV)) u_eng (
    .clk      (clk),
    .rstn     (rstn),
    .start    (eng_start),
    .byte_in  (eng_tx),
    .miso     (SPI_MISO),
    .busy     (eng_busy),
    .done     (eng_done),
    .byte_out (eng_rx),
    .sck      (SPI_CLK),
    .mosi     (SPI_MOSI)
  );

  assign SPI_CS        = cs_q;
  assign busy          = busy_q;
  assign writeNameEn   = nen_q;
  assign writeNameAddr = naddr_q;
  assign writeNameData = ndata_q;
  assign writeAttrEn   = aen_q;
  assign writeAttrAddr = aaddr_q;
  assign writeAttrData = adata_q;

  always_comb begin
    rise_n  = flashReadNametableFlag & ~flagn_q;
    rise_a  = flashReadAttributeFlag & ~flaga_q;
    shn_d   = shn_q;
    sha_d   = sha_q;
    if (rise_n) shn_d = '{1'b0, flashAddrNametable, nametableRamAddrStart};
    if (rise_a) sha_d = '{1'b1, flashAddrAttribute, attributeRamAddrStart};
    state_d   = state_q;
    cur_d     = cur_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    word_d    = word_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    take_n    = 1'b0;
    take_a    = 1'b0;
    eng_start = 1'b0;
    eng_tx    = '0;
    nen_d     = '0;
    naddr_d   = naddr_q;
    ndata_d   = ndata_q;
    aen_d     = '0;
    aaddr_d   = aaddr_q;
    adata_d   = adata_q;
    wr_addr   = cur_q.ram + 9'(idx_q >> 2);
    wr_data   = {eng_rx, word_q};
    last      = idx_q == (cur_q.attr ? IW'(ATTR_BYTES - 1)
                                     : IW'(NAME_BYTES - 1));
    unique case (state_q)
      ST_IDLE: begin
        if (pendn_q || penda_q) begin
          take_n  = pendn_q;
          take_a  = !pendn_q;
          cur_d   = pendn_q ? shn_q : sha_q;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (!eng_busy) begin
          eng_start = 1'b1;
          eng_tx    = LD_OPCODE;
        end else if (eng_done) begin
          eng_start   = 1'b1;
          eng_tx      = cur_q.faddr[23:16];
          cur_d.faddr = {cur_q.faddr[15:0], 8'h00};
          idx_d       = '0;
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (eng_done) begin
          eng_start = 1'b1;
          if (idx_q == IW'(2)) begin
            idx_d = '0;
`ifdef FLASH_FAST_READ_EN
            state_d = ST_DUMMY;
`else
            state_d = ST_DATA;
`endif
          end else begin
            eng_tx      = cur_q.faddr[23:16];
            cur_d.faddr = {cur_q.faddr[15:0], 8'h00};
            idx_d       = idx_q + 1'b1;
          end
        end
      end
`ifdef FLASH_FAST_READ_EN
      ST_DUMMY: begin
        if (eng_done) begin
          eng_start = 1'b1;
          state_d   = ST_DATA;
        end
      end
`endif
      ST_DATA: begin
        if (eng_done) begin
          word_d = wr_data[31:8];
          if (idx_q[1:0] == 2'b11) begin
            if (cur_q.attr) begin
              aen_d   = 4'hF;
              aaddr_d = wr_addr;
              adata_d = wr_data;
            end else begin
              nen_d   = 4'hF;
              naddr_d = wr_addr;
              ndata_d = wr_data;
            end
          end
          if (last) begin
            cs_d    = 1'b1;
            hold_d  = '0;
            state_d = ST_DONE;
          end else begin
            eng_start = 1'b1;
            idx_d     = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        hold_d = hold_q + 1'b1;
        // CS stays high through the hold so the flash sees a clean deselect
        if (hold_q == IW'(2 * CLK_DIV - 1)) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pendn_d = (pendn_q & ~take_n) | rise_n;
    penda_d = (penda_q & ~take_a) | rise_a;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      shn_q   <= '0;
      sha_q   <= '0;
      cur_q   <= '0;
      flagn_q <= 1'b0;
      flaga_q <= 1'b0;
      pendn_q <= 1'b0;
      penda_q <= 1'b0;
      idx_q   <= '0;
      hold_q  <= '0;
      word_q  <= '0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      nen_q   <= '0;
      naddr_q <= '0;
      ndata_q <= '0;
      aen_q   <= '0;
      aaddr_q <= '0;
      adata_q <= '0;
    end else begin
      state_q <= state_d;
      shn_q   <= shn_d;
      sha_q   <= sha_d;
      cur_q   <= cur_d;
      flagn_q <= flashReadNametableFlag;
      flaga_q <= flashReadAttributeFlag;
      pendn_q <= pendn_d;
      penda_q <= penda_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      word_q  <= word_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      nen_q   <= nen_d;
      naddr_q <= naddr_d;
      ndata_q <= ndata_d;
      aen_q   <= aen_d;
      aaddr_q <= aaddr_d;
      adata_q <= adata_d;
    end
  end

endmodule
